// File: rtl/riscv_pkg.sv
// Shared constants and types for the single-cycle RV32I-subset core.
package riscv_pkg;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct3 encodings
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;

  // funct7 encodings
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4,
    WB_IMM
  } wb_sel_t;

  // Map funct3 (plus the funct7 "alternate" bit) onto an ALU operation.
  function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/single_cycle_top_imem.sv
// Byte-addressed instruction memory with a combinational little-endian word fetch.
// Contents are preloaded from outside; there is no write port.
module single_cycle_top_imem #(
  parameter int IMEM_BYTES = 256,
  localparam int AW = $clog2(IMEM_BYTES)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);

  logic [7:0] instructionMem [0:IMEM_BYTES-1];

  logic [AW-1:0] a1_s;
  logic [AW-1:0] a2_s;
  logic [AW-1:0] a3_s;

  // Byte addresses wrap naturally at the memory size
  assign a1_s = addr + AW'(1);
  assign a2_s = addr + AW'(2);
  assign a3_s = addr + AW'(3);

  assign instr = {instructionMem[a3_s], instructionMem[a2_s],
                  instructionMem[a1_s], instructionMem[addr]};

endmodule

// File: rtl/single_cycle_top.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory and writeback
// all complete within one clock; only clock and reset are ports.
module single_cycle_top
  import riscv_pkg::*;
#(
  parameter int IMEM_BYTES = 256,
  parameter int DMEM_BYTES = 256
) (
  input logic clk,
  input logic rst
);

  localparam int IAW    = $clog2(IMEM_BYTES);
  localparam int DAW    = $clog2(DMEM_BYTES);
  localparam int DWORDS = DMEM_BYTES / 4;

  logic [31:0] PC;
  logic [31:0] instr;
  logic [31:0] dataW;

  logic [31:0] regs_r [0:31];
  logic [31:0] dmem_r [0:DWORDS-1];

  // Instruction fields
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;

  // Immediates
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;

  // Decoded control
  logic        reg_we_s;
  logic        mem_we_s;
  logic        alu_a_pc_s;
  logic        alu_b_imm_s;
  logic        branch_s;
  logic        jal_s;
  logic        jalr_s;
  alu_op_t     alu_op_s;
  wb_sel_t     wb_sel_s;
  logic [31:0] imm_s;

  // Datapath
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] alu_a_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_res_s;
  logic [31:0] mem_rdata_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] jalr_tgt_s;
  logic [31:0] next_pc_s;
  logic        br_cond_s;
  logic [DAW-3:0] dmem_idx_s;

  single_cycle_top_imem #(.IMEM_BYTES(IMEM_BYTES)) IM (
    .addr  (PC[IAW-1:0]),
    .instr (instr)
  );

  assign opcode_s = instr[6:0];
  assign rd_s     = instr[11:7];
  assign funct3_s = instr[14:12];
  assign rs1_s    = instr[19:15];
  assign rs2_s    = instr[24:20];
  assign funct7_s = instr[31:25];

  assign imm_i_s = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_s = {instr[31:12], 12'h000};
  assign imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Register reads are combinational; x0 is hardwired to zero
  assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
  assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];

  // Decode opcode/funct fields into control; anything unrecognised becomes a NOP
  always_comb begin
    reg_we_s    = 1'b0;
    mem_we_s    = 1'b0;
    alu_a_pc_s  = 1'b0;
    alu_b_imm_s = 1'b1;
    branch_s    = 1'b0;
    jal_s       = 1'b0;
    jalr_s      = 1'b0;
    alu_op_s    = ALU_ADD;
    wb_sel_s    = WB_ALU;
    imm_s       = imm_i_s;
    case (opcode_s)
      OP_R: begin
        alu_b_imm_s = 1'b0;
        alu_op_s    = alu_op_from_f3(funct3_s, funct7_s[5]);
        if ((funct7_s == F7_BASE) ||
            ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD_SUB) || (funct3_s == F3_SRL_SRA)))) begin
          reg_we_s = 1'b1;
        end else begin
          reg_we_s = 1'b0;
        end
      end
      OP_I: begin
        alu_op_s = alu_op_from_f3(funct3_s, (funct3_s == F3_SRL_SRA) && funct7_s[5]);
        if (funct3_s == F3_SLL) begin
          reg_we_s = (funct7_s == F7_BASE);
        end else if (funct3_s == F3_SRL_SRA) begin
          reg_we_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
        end else begin
          reg_we_s = 1'b1;
        end
      end
      OP_LOAD: begin
        wb_sel_s = WB_MEM;
        reg_we_s = (funct3_s == F3_LW);
      end
      OP_STORE: begin
        imm_s    = imm_s_s;
        mem_we_s = (funct3_s == F3_SW);
      end
      OP_BRANCH: begin
        imm_s       = imm_b_s;
        alu_b_imm_s = 1'b0;
        alu_op_s    = ALU_SUB;
        branch_s    = (funct3_s == F3_BEQ) || (funct3_s == F3_BNE) ||
                      (funct3_s == F3_BLT) || (funct3_s == F3_BGE);
      end
      OP_JAL: begin
        imm_s    = imm_j_s;
        wb_sel_s = WB_PC4;
        jal_s    = 1'b1;
        reg_we_s = 1'b1;
      end
      OP_JALR: begin
        wb_sel_s = WB_PC4;
        jalr_s   = (funct3_s == F3_JALR);
        reg_we_s = (funct3_s == F3_JALR);
      end
      OP_LUI: begin
        imm_s    = imm_u_s;
        wb_sel_s = WB_IMM;
        reg_we_s = 1'b1;
      end
      OP_AUIPC: begin
        imm_s      = imm_u_s;
        alu_a_pc_s = 1'b1;
        reg_we_s   = 1'b1;
      end
      default: begin
        reg_we_s = 1'b0;
      end
    endcase
  end

  assign alu_a_s = alu_a_pc_s ? PC : rs1_val_s;
  assign alu_b_s = alu_b_imm_s ? imm_s : rs2_val_s;

  // ALU
  always_comb begin
    case (alu_op_s)
      ALU_ADD:  alu_res_s = alu_a_s + alu_b_s;
      ALU_SUB:  alu_res_s = alu_a_s - alu_b_s;
      ALU_AND:  alu_res_s = alu_a_s & alu_b_s;
      ALU_OR:   alu_res_s = alu_a_s | alu_b_s;
      ALU_XOR:  alu_res_s = alu_a_s ^ alu_b_s;
      ALU_SLL:  alu_res_s = alu_a_s << alu_b_s[4:0];
      ALU_SRL:  alu_res_s = alu_a_s >> alu_b_s[4:0];
      ALU_SRA:  alu_res_s = 32'($signed(alu_a_s) >>> alu_b_s[4:0]);
      ALU_SLT:  alu_res_s = {31'd0, ($signed(alu_a_s) < $signed(alu_b_s))};
      ALU_SLTU: alu_res_s = {31'd0, (alu_a_s < alu_b_s)};
      default:  alu_res_s = alu_a_s + alu_b_s;
    endcase
  end

  // Word-aligned data-memory index; low two address bits are ignored
  assign dmem_idx_s  = alu_res_s[DAW-1:2];
  assign mem_rdata_s = dmem_r[dmem_idx_s];

  assign pc_plus4_s = PC + 32'd4;
  assign jalr_tgt_s = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;

  // Writeback source selection
  always_comb begin
    case (wb_sel_s)
      WB_ALU:  dataW = alu_res_s;
      WB_MEM:  dataW = mem_rdata_s;
      WB_PC4:  dataW = pc_plus4_s;
      WB_IMM:  dataW = imm_s;
      default: dataW = alu_res_s;
    endcase
  end

  // Branch condition evaluation on the two register operands
  always_comb begin
    case (funct3_s)
      F3_BEQ:  br_cond_s = (rs1_val_s == rs2_val_s);
      F3_BNE:  br_cond_s = (rs1_val_s != rs2_val_s);
      F3_BLT:  br_cond_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
      F3_BGE:  br_cond_s = !($signed(rs1_val_s) < $signed(rs2_val_s));
      default: br_cond_s = 1'b0;
    endcase
  end

  // Next-PC selection
  always_comb begin
    if (jal_s) begin
      next_pc_s = PC + imm_j_s;
    end else if (jalr_s) begin
      next_pc_s = jalr_tgt_s;
    end else if (branch_s && br_cond_s) begin
      next_pc_s = PC + imm_b_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Program counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC <= 32'd0;
    end else begin
      PC <= next_pc_s;
    end
  end

  // Register file write port; x0 writes are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (reg_we_s && (rd_s != 5'd0)) begin
      regs_r[rd_s] <= dataW;
    end
  end

  // Data-memory write port; contents survive reset but no store happens while held in reset
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      dmem_r[dmem_idx_s] <= rs2_val_s;
    end
  end

endmodule

// File: tb/tb_single_cycle_top.sv
// Directed bench for single_cycle_top: loads a short program into the
// instruction memory and checks PC, instr, dataW and registers step by step.
module tb_single_cycle_top;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  single_cycle_top #(.IMEM_BYTES(256), .DMEM_BYTES(256)) dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_word(input int addr, input logic [31:0] w);
    dut.IM.instructionMem[addr]     = w[7:0];
    dut.IM.instructionMem[addr + 1] = w[15:8];
    dut.IM.instructionMem[addr + 2] = w[23:16];
    dut.IM.instructionMem[addr + 3] = w[31:24];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;

    for (int a = 0; a < 256; a++) begin
      dut.IM.instructionMem[a] = 8'h00;
    end
    load_word(32'h00, 32'h00500093); // addi x1,x0,5
    load_word(32'h04, 32'h00700113); // addi x2,x0,7
    load_word(32'h08, 32'h002081B3); // add  x3,x1,x2
    load_word(32'h0C, 32'h40208233); // sub  x4,x1,x2
    load_word(32'h10, 32'h00108463); // beq  x1,x1,+8
    load_word(32'h14, 32'h00100393); // addi x7,x0,1
    load_word(32'h18, 32'h00302423); // sw   x3,8(x0)
    load_word(32'h1C, 32'h00802283); // lw   x5,8(x0)
    load_word(32'h20, 32'h00C0036F); // jal  x6,+12
    load_word(32'h24, 32'h00028413); // addi x8,x5,0
    load_word(32'h28, 32'h001224B3); // slt  x9,x4,x1
    load_word(32'h2C, 32'h00030067); // jalr x0,0(x6)

    #12 rst = 1'b0;
    #8; // t = 20, still in reset
    check("reset_pc",    dut.PC,        32'h00000000);
    check("reset_instr", dut.instr,     32'h00500093);
    check("reset_dataW", dut.dataW,     32'h00000005);
    check("reset_x1",    dut.regs_r[1], 32'h00000000);
    #4 rst = 1'b1; // t = 24

    @(negedge clk); // t = 30
    check("addi2_pc",    dut.PC,        32'h00000004);
    check("addi2_dataW", dut.dataW,     32'h00000007);
    check("x1_after",    dut.regs_r[1], 32'h00000005);
    @(negedge clk);
    check("add_pc",      dut.PC,        32'h00000008);
    check("add_dataW",   dut.dataW,     32'h0000000C);
    @(negedge clk);
    check("sub_dataW",   dut.dataW,     32'hFFFFFFFE);
    @(negedge clk);
    check("beq_pc",      dut.PC,        32'h00000010);
    @(negedge clk);
    check("beq_taken",   dut.PC,        32'h00000018);
    check("sw_dataW",    dut.dataW,     32'h00000008);
    @(negedge clk);
    check("lw_pc",       dut.PC,        32'h0000001C);
    check("lw_dataW",    dut.dataW,     32'h0000000C);
    check("dmem_word2",  dut.dmem_r[2], 32'h0000000C);
    @(negedge clk);
    check("jal_pc",      dut.PC,        32'h00000020);
    check("jal_dataW",   dut.dataW,     32'h00000024);
    check("x5_after_lw", dut.regs_r[5], 32'h0000000C);
    check("x7_skipped",  dut.regs_r[7], 32'h00000000);
    @(negedge clk);
    check("jal_target",  dut.PC,        32'h0000002C);
    check("x6_link",     dut.regs_r[6], 32'h00000024);
    @(negedge clk);
    check("jalr_target", dut.PC,        32'h00000024);
    check("mov_x5",      dut.dataW,     32'h0000000C);
    @(negedge clk);
    check("slt_pc",      dut.PC,        32'h00000028);
    check("slt_dataW",   dut.dataW,     32'h00000001);

    // Second run: patch the branch to bne so execution falls through to 0x14
    load_word(32'h10, 32'h00109463); // bne x1,x1,+8
    #2 rst = 1'b0;
    #1;
    check("async_rst_pc",  dut.PC,        32'h00000000);
    check("async_rst_x1",  dut.regs_r[1], 32'h00000000);
    check("async_rst_x8",  dut.regs_r[8], 32'h00000000);
    check("dmem_kept",     dut.dmem_r[2], 32'h0000000C);
    @(negedge clk); // one rising edge held in reset
    check("held_rst_pc",   dut.PC,        32'h00000000);
    check("held_rst_x1",   dut.regs_r[1], 32'h00000000);
    rst = 1'b1;
    @(negedge clk);
    check("restart_pc",    dut.PC,        32'h00000004);
    check("restart_x1",    dut.regs_r[1], 32'h00000005);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("bne_pc",        dut.PC,        32'h00000010);
    check("bne_instr",     dut.instr,     32'h00109463);
    @(negedge clk);
    check("bne_fallthru",  dut.PC,        32'h00000014);
    check("x3_second",     dut.regs_r[3], 32'h0000000C);

    // Reset while sitting at 0x14
    #2 rst = 1'b0;
    #1;
    check("mid_rst_pc",    dut.PC,        32'h00000000);
    check("mid_rst_x3",    dut.regs_r[3], 32'h00000000);
    check("mid_rst_x7",    dut.regs_r[7], 32'h00000000);
    check("mid_rst_dataW", dut.dataW,     32'h00000005);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rerun_pc",      dut.PC,        32'h00000004);
    check("rerun_dataW",   dut.dataW,     32'h00000007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/single_cycle_top.md
# single_cycle_top

Top level of a single-cycle RV32I-subset processor. Each rising clock edge fetches one instruction from a byte-addressed instruction memory, decodes it, and executes it completely. Execution covers ALU work, a data-memory access, register writeback and the PC update. The block is self-contained: its only ports are clock and reset. Program load and observation use hierarchical access to named internal signals.

## Interface
- IMEM_BYTES, default 256: instruction-memory size in bytes (power of two).
- DMEM_BYTES, default 256: data-memory size in bytes (power of two).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- Hierarchically visible internal state, fixed names required:
  - PC: 32-bit program counter.
  - instr: 32-bit current instruction.
  - dataW: 32-bit writeback data.
  - IM: instruction-memory instance, containing byte array instructionMem[0:IMEM_BYTES-1] (8 bits per entry).

## Operation
- Fetch:
  - instr = {instructionMem[PC+3], instructionMem[PC+2], instructionMem[PC+1], instructionMem[PC]} (little-endian).
  - Address taken modulo IMEM_BYTES.
  - Fetch is combinational.
  - IM has no write port; it is loaded by the bench only.
- Supported instructions:
  - R-type: add, sub, and, or, xor, sll, srl, sra, slt, sltu.
  - I-type ALU: addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - Memory: lw, sw.
  - Branches: beq, bne, blt, bge.
  - Jumps: jal, jalr.
  - Upper immediates: lui, auipc.
- Immediates are sign-extended per RV32I I/S/B/U/J formats.
- Register file:
  - 32 x 32-bit, two combinational read ports, one synchronous write port.
  - x0 always reads 0; writes to x0 are discarded.
- dataW (writeback mux):
  - Memory read data for lw.
  - PC+4 for jal and jalr.
  - Immediate for lui.
  - ALU result for all other instructions.
  - Valid every cycle, including for instructions that do not write back.
- Data memory:
  - Word access at (addr & ~3) modulo DMEM_BYTES, little-endian.
  - Combinational read; write on the rising edge for sw.
- Next PC:
  - Branch taken: PC + immB.
  - jal: PC + immJ.
  - jalr: (rs1 + immI) & ~1.
  - Otherwise: PC + 4.
  - Wraps at 2^32.
- Unsupported or illegal opcode: executes as a NOP (no register or memory write, PC+4).
- Misaligned word accesses are silently aligned down; no exceptions are raised.

## Timing
- CPI = 1. PC, register file and data memory all update on the same rising edge.
- Instruction effects are visible on the next edge:
  - A result written at edge N is readable as an operand during the following cycle.
  - Register-file reads are combinational from current state; no write-through bypass is needed.
- Reset (rst = 0) asynchronously forces:
  - PC = 0.
  - All 32 registers = 0.
- Reset does not clear data memory or instruction memory.
- Asserting rst mid-program aborts the current instruction: no register or memory write occurs while rst = 0.
- After rst is released, the first rising edge executes the instruction at address 0.
- With rst = 0, instr and dataW still reflect the instruction at PC = 0, computed combinationally.

## Structure
- Shared package riscv_pkg holds:
  - Opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - funct3/funct7 constants.
  - ALU-op enum alu_op_t.
  - Writeback-select enum.
- The one natural sub-module is the instruction memory, instantiated with instance name IM, so that IM.instructionMem is reachable.
- Register file, ALU, immediate generator, decoder and data memory may be inline logic in the top.

## Test plan
Clock period 10 ns; rst low from 12 ns to 24 ns. Program loaded byte-wise into IM.instructionMem.
- addi x1,x0,5 then addi x2,x0,7:
  - dataW = 5 then 7.
  - PC sequence 0, 4, 8.
- add x3,x1,x2 → dataW = 0x0000000C. sub x4,x1,x2 → dataW = 0xFFFFFFFE.
- sw x3,8(x0) then lw x5,8(x0):
  - lw gives dataW = 0x0C.
  - x5 = 12 afterwards.
- Branches:
  - beq x1,x1,+8 skips one instruction: PC goes 0x10 → 0x18.
  - bne x1,x1,+8 falls through to PC+4.
- Jumps:
  - jal x6,+12 at PC 0x20 → x6 = 0x24, next PC = 0x2C.
  - jalr x0,0(x6) → PC = 0x24.
- Reset mid-run:
  - Pull rst low while PC = 0x14 → PC = 0 immediately and registers read 0.
  - Execution restarts at address 0 after release.
